// File: rtl/mux.sv
// mux: selects one N-bit word out of an S*N-bit packed vector.
//   a    in   S*N    packed words; word k at a[k*N +: N]
//   sel  in   SEL_W  word index
//   y    out  N      a[sel*N +: N], or 0 when sel >= S
module mux #(
    parameter int unsigned N = 4,
    parameter int unsigned S = 16,
    localparam int unsigned SEL_W = $clog2(S)
) (
    input  logic [S*N-1:0]   a,
    input  logic [SEL_W-1:0] sel,
    output logic [N-1:0]     y
);

    always_comb begin
        y = '0;
        for (int k = 0; k < int'(S); k++) begin
            if (sel == SEL_W'(k)) begin
                y = a[k*N +: N];
            end
        end
    end

endmodule

// File: rtl/demux_packer.sv
// demux_packer: collects slot-tagged N-bit words into an S*N-bit frame and hands the
// frame out on a valid/ready interface once every slot has been written.
//   clk        in   1        rising-edge clock
//   rst        in   1        asynchronous active-high reset
//   clear      in   1        synchronous abort of the current frame
//   in_valid   in   1        input word valid
//   in_ready   out  1        block can accept a word (FILL state)
//   in_sel     in   SEL_W    destination slot of in_data
//   in_data    in   N        input word
//   out_valid  out  1        full frame available (FULL state)
//   out_ready  in   1        consumer accepts the frame
//   out_data   out  S*N      packed frame; slot k at [k*N +: N]
//   fill_cnt   out  SEL_W+1  distinct slots written in the current frame
//   err_sel    out  1        one-cycle pulse after an accepted word with in_sel >= S
//   rd_sel     in   SEL_W    readback slot select
//   rd_data    out  N        out_data[rd_sel*N +: N]
module demux_packer #(
    parameter int unsigned N = 4,
    parameter int unsigned S = 16,
    localparam int unsigned SEL_W = $clog2(S)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic [N-1:0]       in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [S*N-1:0]     out_data,
    output logic [SEL_W:0]     fill_cnt,
    output logic               err_sel,
    input  logic [SEL_W-1:0]   rd_sel,
    output logic [N-1:0]       rd_data
);

    typedef enum logic [0:0] {
        StFill = 1'b0,
        StFull = 1'b1
    } state_e;

    state_e             r_state, w_state_d;
    logic [S-1:0]       r_mask, w_mask_d;
    logic [S*N-1:0]     r_data, w_data_d;
    logic [SEL_W:0]     r_fill_cnt, w_fill_cnt_d;
    logic               r_err_sel, w_err_sel_d;
    logic               w_sel_ok;
    logic               w_new_slot;

    // SEL_W bits can encode indices past S-1 when S is not a power of two.
    assign w_sel_ok = 32'(in_sel) < S;

    always_comb begin
        w_state_d    = r_state;
        w_mask_d     = r_mask;
        w_data_d     = r_data;
        w_fill_cnt_d = r_fill_cnt;
        w_err_sel_d  = 1'b0;
        w_new_slot   = 1'b0;
        if (clear) begin
            // Wins over a simultaneous accept (word dropped) or hand-off.
            w_mask_d     = '0;
            w_fill_cnt_d = '0;
            w_state_d    = StFill;
        end else begin
            unique case (r_state)
                StFill: begin
                    if (in_valid) begin
                        if (w_sel_ok) begin
                            for (int k = 0; k < int'(S); k++) begin
                                if (in_sel == SEL_W'(k)) begin
                                    w_data_d[k*N +: N] = in_data;
                                    w_mask_d[k]        = 1'b1;
                                    w_new_slot         = ~r_mask[k];
                                end
                            end
                            if (w_new_slot) begin
                                w_fill_cnt_d = r_fill_cnt + {{SEL_W{1'b0}}, 1'b1};
                            end
                            if (&w_mask_d) begin
                                w_state_d = StFull;
                            end
                        end else begin
                            w_err_sel_d = 1'b1;
                        end
                    end
                end
                StFull: begin
                    // Data is kept; only the mask restarts, so every slot is rewritten.
                    if (out_ready) begin
                        w_mask_d     = '0;
                        w_fill_cnt_d = '0;
                        w_state_d    = StFill;
                    end
                end
                default: w_state_d = StFill;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StFill;
            r_mask     <= '0;
            r_data     <= '0;
            r_fill_cnt <= '0;
            r_err_sel  <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_mask     <= w_mask_d;
            r_data     <= w_data_d;
            r_fill_cnt <= w_fill_cnt_d;
            r_err_sel  <= w_err_sel_d;
        end
    end

    assign in_ready  = (r_state == StFill);
    assign out_valid = (r_state == StFull);
    assign out_data  = r_data;
    assign fill_cnt  = r_fill_cnt;
    assign err_sel   = r_err_sel;

    mux #(
        .N (N),
        .S (S)
    ) u_rd_mux (
        .a   (r_data),
        .sel (rd_sel),
        .y   (rd_data)
    );

endmodule

// File: tb/tb_demux_packer.sv
// Testbench for demux_packer: a 16-slot instance driven through full frames with a
// scoreboard on the frame hand-off, plus a 12-slot instance for out-of-range selects.
module tb_demux_packer;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // S = 16 instance
    logic        clear, in_valid, in_ready, out_valid, out_ready, err_sel;
    logic [3:0]  in_sel, in_data, rd_sel, rd_data;
    logic [63:0] out_data;
    logic [4:0]  fill_cnt;

    // S = 12 instance
    logic        clear_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, err_sel_b;
    logic [3:0]  in_sel_b, in_data_b, rd_sel_b, rd_data_b;
    logic [47:0] out_data_b;
    logic [4:0]  fill_cnt_b;

    demux_packer #(.N(4), .S(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .fill_cnt  (fill_cnt),
        .err_sel   (err_sel),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data)
    );

    demux_packer #(.N(4), .S(12)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear_b),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .in_sel    (in_sel_b),
        .in_data   (in_data_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready_b),
        .out_data  (out_data_b),
        .fill_cnt  (fill_cnt_b),
        .err_sel   (err_sel_b),
        .rd_sel    (rd_sel_b),
        .rd_data   (rd_data_b)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered just after a falling edge; the word is taken on the next rising edge.
    task automatic wr(input logic [3:0] sel, input logic [3:0] d);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wr_b(input logic [3:0] sel, input logic [3:0] d);
        in_valid_b = 1'b1;
        in_sel_b   = sel;
        in_data_b  = d;
        @(negedge clk);
        in_valid_b = 1'b0;
    endtask

    // Scoreboard monitor: compares every handed-off frame against the queue.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (out_valid && out_ready && !rst && !clear) begin
                if (exp_q.size() == 0) begin
                    chk("frame_unexpected", out_data, 64'hx);
                end else begin
                    chk("frame_data", out_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [63:0] held;
        int          exp_cnt;
        rst = 1'b1;
        clear = 1'b0; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = 1'b0;
        rd_sel = '0;
        clear_b = 1'b0; in_valid_b = 1'b0; in_sel_b = '0; in_data_b = '0;
        out_ready_b = 1'b0; rd_sel_b = '0;

        // Reset values
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_fill_cnt", 64'(fill_cnt), 64'd0);
        chk("rst_err_sel", 64'(err_sel), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1. Fill slots 0..15 with 0xF-k
        for (int k = 0; k < 16; k++) begin
            wr(4'(k), 4'(15 - k));
            if (k < 15) begin
                chk("t1_not_full", 64'(out_valid), 64'd0);
                chk("t1_fill_cnt", 64'(fill_cnt), 64'(k + 1));
            end
        end
        exp_q.push_back(64'h0123456789ABCDEF);
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_in_ready", 64'(in_ready), 64'd0);
        chk("t1_fill_cnt16", 64'(fill_cnt), 64'd16);
        chk("t1_out_data", out_data, 64'h0123456789ABCDEF);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            rd_sel = 4'(k);
            #1;
            chk("t1_rd_data", 64'(rd_data), 64'(15 - k));
        end
        @(negedge clk);

        // 2. Words offered while FULL are ignored; then hand off
        held = 64'h0123456789ABCDEF;
        in_valid = 1'b1; in_sel = 4'd0; in_data = 4'h5;
        repeat (3) begin
            @(negedge clk);
            chk("t2_in_ready", 64'(in_ready), 64'd0);
            chk("t2_out_stable", out_data, held);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("t2_out_valid", 64'(out_valid), 64'd0);
        chk("t2_in_ready_back", 64'(in_ready), 64'd1);
        chk("t2_fill_cnt", 64'(fill_cnt), 64'd0);

        // 3. Slot 5 written twice, then the other 15 slots with value k
        wr(4'd5, 4'h3);
        chk("t3_cnt_first", 64'(fill_cnt), 64'd1);
        wr(4'd5, 4'hC);
        chk("t3_cnt_overwrite", 64'(fill_cnt), 64'd1);
        rd_sel = 4'd5;
        #1;
        chk("t3_rd_slot5", 64'(rd_data), 64'hC);
        exp_cnt = 1;
        for (int k = 0; k < 16; k++) begin
            if (k != 5) begin
                wr(4'(k), 4'(k));
                exp_cnt++;
                chk("t3_fill_cnt", 64'(fill_cnt), 64'(exp_cnt));
                chk("t3_out_valid", 64'(out_valid), (exp_cnt == 16) ? 64'd1 : 64'd0);
            end
        end
        exp_q.push_back(64'hFEDCBA9876C43210);
        chk("t3_slot5", 64'(out_data[20 +: 4]), 64'hC);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("t3_handoff", 64'(in_ready), 64'd1);

        // 4. S = 12: out-of-range selects are consumed and flagged
        wr_b(4'd0, 4'h9);
        chk("t4_cnt1", 64'(fill_cnt_b), 64'd1);
        in_valid_b = 1'b1; in_sel_b = 4'd13; in_data_b = 4'h2;
        chk("t4_accepted", 64'(in_ready_b), 64'd1);
        @(negedge clk);
        in_valid_b = 1'b0;
        chk("t4_err_pulse", 64'(err_sel_b), 64'd1);
        chk("t4_cnt_same", 64'(fill_cnt_b), 64'd1);
        chk("t4_state_same", 64'(in_ready_b), 64'd1);
        chk("t4_data_same", 64'(out_data_b), 64'h9);
        @(negedge clk);
        chk("t4_err_one_cycle", 64'(err_sel_b), 64'd0);
        wr_b(4'd12, 4'h7);
        chk("t4_err_sel12", 64'(err_sel_b), 64'd1);
        wr_b(4'd0, 4'h0);
        chk("t4_cnt_overwrite", 64'(fill_cnt_b), 64'd1);
        for (int k = 1; k < 12; k++) begin
            chk("t4_not_full", 64'(out_valid_b), 64'd0);
            wr_b(4'(k), 4'(k));
        end
        chk("t4_full", 64'(out_valid_b), 64'd1);
        chk("t4_fill12", 64'(fill_cnt_b), 64'd12);
        chk("t4_frame", 64'(out_data_b), 64'h0000BA9876543210);
        // clear while FULL drops the frame
        clear_b = 1'b1;
        @(negedge clk);
        clear_b = 1'b0;
        chk("t4_clear_full_valid", 64'(out_valid_b), 64'd0);
        chk("t4_clear_full_ready", 64'(in_ready_b), 64'd1);
        chk("t4_clear_full_cnt", 64'(fill_cnt_b), 64'd0);

        // 5. clear together with an accept after 7 words
        for (int k = 0; k < 7; k++) begin
            wr(4'(k), 4'hA);
        end
        chk("t5_cnt7", 64'(fill_cnt), 64'd7);
        clear = 1'b1; in_valid = 1'b1; in_sel = 4'd7; in_data = 4'h5;
        chk("t5_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        chk("t5_cnt0", 64'(fill_cnt), 64'd0);
        chk("t5_in_ready", 64'(in_ready), 64'd1);
        rd_sel = 4'd7;
        #1;
        chk("t5_word_dropped", 64'(rd_data), 64'h7);
        for (int k = 0; k < 15; k++) begin
            wr(4'(k), 4'(15 - k));
        end
        chk("t5_needs_all", 64'(out_valid), 64'd0);
        chk("t5_cnt15", 64'(fill_cnt), 64'd15);
        wr(4'd15, 4'h0);
        exp_q.push_back(64'h0123456789ABCDEF);
        chk("t5_full", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // 6. asynchronous reset with 10 slots filled
        for (int k = 0; k < 10; k++) begin
            wr(4'(k), 4'h3);
        end
        chk("t6_cnt10", 64'(fill_cnt), 64'd10);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_fill_cnt", 64'(fill_cnt), 64'd0);
        chk("t6_out_data", out_data, 64'd0);
        chk("t6_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        // Every pushed frame must have been handed off
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
